// File: rtl/mem_scan_reader.sv
// mem_scan_reader: walks every address of a synchronous-read memory in
// order and presents each word as an (address, data) beat on a
// valid/ready stream, while counting words that are all-ones.
//
// Optional feature: define MEM_SCAN_CLEAR_EN for read-and-clear mode.
// In that mode each accepted beat writes zero back to its address, so a
// completed scan leaves the memory all-zero.
module mem_scan_reader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
`ifdef MEM_SCAN_CLEAR_EN
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sat_count
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        OUT,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [DATA_W-1:0] SAT_WORD  = '1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_q;
    logic              fresh;
    logic              accept;

    assign accept   = out_valid & out_ready;
    assign mem_addr = addr;

    // The read strobe in READ returns its word one cycle later, i.e. in the
    // first OUT cycle. That cycle shows the memory port directly and latches
    // it, so later (stalled) OUT cycles replay the held copy.
    assign out_data = fresh ? mem_rd_data : data_q;

`ifdef MEM_SCAN_CLEAR_EN
    // During the accept cycle mem_addr already equals out_addr, so the
    // write lands on the word that was just handed to the consumer.
    assign mem_wr_en   = accept;
    assign mem_wr_data = '0;
`endif

    // Scan sequencer: state, address, beat registers and saturation count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            mem_rd_en <= 1'b0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            data_q    <= '0;
            fresh     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_count <= '0;
        end else begin
            // NOTE: every register here uses <= so all updates see the
            // values from before the edge, regardless of statement order.
            case (state)
                IDLE: begin
                    if (start) begin
                        addr      <= '0;
                        sat_count <= '0;
                        mem_rd_en <= 1'b1;
                        busy      <= 1'b1;
                        state     <= READ;
                    end
                end

                READ: begin
                    mem_rd_en <= 1'b0;
                    out_addr  <= addr;
                    out_valid <= 1'b1;
                    fresh     <= 1'b1;
                    state     <= OUT;
                end

                OUT: begin
                    if (fresh) begin
                        data_q <= mem_rd_data;
                        fresh  <= 1'b0;
                        if (mem_rd_data == SAT_WORD) begin
                            sat_count <= sat_count + 1'b1;
                        end
                    end
                    if (accept) begin
                        out_valid <= 1'b0;
                        if (addr == LAST_ADDR) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            addr      <= addr + 1'b1;
                            mem_rd_en <= 1'b1;
                            state     <= READ;
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_scan_reader.sv
// Directed testbench for mem_scan_reader with a behavioural 256 x 16
// synchronous-read memory. Define MEM_SCAN_CLEAR_EN to exercise the
// read-and-clear build.
module tb_mem_scan_reader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 256;
`ifdef MEM_SCAN_CLEAR_EN
    localparam bit CLEAR = 1'b1;
`else
    localparam bit CLEAR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rd_data;
`ifdef MEM_SCAN_CLEAR_EN
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wr_data;
    int                wr_count;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   sat_count;

    mem_scan_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
`ifdef MEM_SCAN_CLEAR_EN
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data),
`endif
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_addr    (out_addr),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .sat_count   (sat_count)
    );

    always #5 clk = ~clk;

    // Memory contents are written only by the test process; this block only reads.
    logic [DATA_W-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Expected beat data and what the last scan produced.
    logic [DATA_W-1:0] exp_data [DEPTH];
    logic [ADDR_W-1:0] beat_addr [DEPTH];
    logic [DATA_W-1:0] beat_data [DEPTH];
    int                n_beats, edges, done_edge, done_count, first_valid_edge;
    int                unstable, rd_in_out, stalls, first_bad;
    logic [ADDR_W:0]   sat_at_done, sat_first;

    // One clock: commit a pending clear-write, take the edge, settle.
    task automatic step();
`ifdef MEM_SCAN_CLEAR_EN
        if (mem_wr_en) begin
            mem[mem_addr] = mem_wr_data;
            wr_count++;
        end
`endif
        @(posedge clk);
        #1;
    endtask

    task automatic load_preload();
        for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'(i);
        mem[5]   = 16'hFFFF;
        mem[200] = 16'hFFFF;
        for (int i = 0; i < DEPTH; i++) exp_data[i] = mem[i];
    endtask

    task automatic load_ones();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]      = 16'hFFFF;
            exp_data[i] = 16'hFFFF;
        end
    endtask

    function automatic int count_bad();
        int bad = 0;
        first_bad = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (beat_addr[i] !== ADDR_W'(i) || beat_data[i] !== exp_data[i]) begin
                if (first_bad < 0) first_bad = i;
                bad++;
            end
        end
        return bad;
    endfunction

    // Run one scan from a start pulse to one cycle past done, recording beats.
    // ready_mode 0 holds out_ready high, 1 randomises it. inj_edge / inj_done
    // raise start again mid-scan / in the DONE cycle.
    task automatic run_scan(input int ready_mode, input int inj_edge, input bit inj_done);
        logic              have_hold;
        logic [ADDR_W-1:0] hold_addr;
        logic [DATA_W-1:0] hold_data;
        bit                timed_out;
        n_beats = 0; done_edge = -1; done_count = 0; first_valid_edge = -1;
        unstable = 0; rd_in_out = 0; stalls = 0; have_hold = 1'b0; timed_out = 1'b0;
        sat_at_done = 'x; sat_first = 'x; hold_addr = '0; hold_data = '0;
`ifdef MEM_SCAN_CLEAR_EN
        wr_count = 0;
`endif
        start = 1'b1;
        step();
        start = 1'b0;
        edges = 0;
        forever begin
            out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            start     = (edges == inj_edge) || (inj_done && done);
            #1;
            if (out_valid) begin
                if (first_valid_edge < 0) first_valid_edge = edges;
                if (have_hold && (out_addr !== hold_addr || out_data !== hold_data)) unstable++;
                if (mem_rd_en) rd_in_out++;
                if (out_ready) begin
                    if (n_beats < DEPTH) begin
                        beat_addr[n_beats] = out_addr;
                        beat_data[n_beats] = out_data;
                    end
                    if (n_beats == 0) sat_first = sat_count;
                    n_beats++;
                    have_hold = 1'b0;
                end else begin
                    stalls++;
                    have_hold = 1'b1;
                    hold_addr = out_addr;
                    hold_data = out_data;
                end
            end else if (have_hold) begin
                unstable++;
                have_hold = 1'b0;
            end
            if (done) begin
                done_count++;
                if (done_edge < 0) begin
                    done_edge   = edges;
                    sat_at_done = sat_count;
                end
            end
            step();
            start = 1'b0;
            edges++;
            if (done_edge >= 0) break;
            if (edges > 4000) begin
                timed_out = 1'b1;
                break;
            end
        end
        n_checks++; if (timed_out !== 1'b0) begin n_fail++; $display("FAIL scan_timeout: no done after %0d cycles, expected done", edges); end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        repeat (3) step();
        n_checks++; if (mem_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0b expected 0", mem_rd_en); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL reset_mem_addr: got %0h expected 0", mem_addr); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++; if (out_addr !== 8'h00) begin n_fail++; $display("FAIL reset_out_addr: got %0h expected 0", out_addr); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b expected 0", done); end
        n_checks++; if (sat_count !== 9'h000) begin n_fail++; $display("FAIL reset_sat_count: got %0h expected 0", sat_count); end
        rst = 1'b0;
        repeat (2) step();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_without_start: busy got %0b expected 0", busy); end
    endtask

    task automatic test_full_scan();
        int bad;
        load_preload();
        run_scan(0, -1, 1'b0);
        bad = count_bad();
        n_checks++; if (first_valid_edge !== 1) begin n_fail++; $display("FAIL full_first_valid: got cycle %0d expected 1", first_valid_edge); end
        n_checks++; if (n_beats !== 256) begin n_fail++; $display("FAIL full_beats: got %0d expected 256", n_beats); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL full_sequence: %0d wrong beats, first at %0d", bad, first_bad); end
        n_checks++; if (done_edge !== 512) begin n_fail++; $display("FAIL full_done_time: got %0d edges after start expected 512", done_edge); end
        n_checks++; if (sat_at_done !== 9'd2) begin n_fail++; $display("FAIL full_sat_count: got %0d expected 2", sat_at_done); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL full_done_one_cycle: got %0b expected 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL full_busy_after: got %0b expected 0", busy); end
        n_checks++; if (sat_count !== 9'd2) begin n_fail++; $display("FAIL full_sat_hold: got %0d expected 2", sat_count); end
`ifdef MEM_SCAN_CLEAR_EN
        n_checks++; if (wr_count !== 256) begin n_fail++; $display("FAIL full_clear_writes: got %0d expected 256", wr_count); end
`endif
    endtask

    task automatic test_backpressure();
        int bad;
        load_preload();
        run_scan(1, -1, 1'b0);
        bad = count_bad();
        n_checks++; if (n_beats !== 256) begin n_fail++; $display("FAIL bp_beats: got %0d expected 256", n_beats); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_sequence: %0d wrong beats, first at %0d", bad, first_bad); end
        n_checks++; if (stalls === 0) begin n_fail++; $display("FAIL bp_stalls: got %0d stall cycles expected >0", stalls); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled expected 0", unstable); end
        n_checks++; if (rd_in_out !== 0) begin n_fail++; $display("FAIL bp_no_reads: got %0d reads while valid expected 0", rd_in_out); end
        n_checks++; if (sat_at_done !== 9'd2) begin n_fail++; $display("FAIL bp_sat_count: got %0d expected 2", sat_at_done); end
        n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL bp_done_count: got %0d expected 1", done_count); end
    endtask

    task automatic test_ignored_start();
        int bad;
        load_preload();
        run_scan(0, 100, 1'b1);
        bad = count_bad();
        n_checks++; if (n_beats !== 256) begin n_fail++; $display("FAIL ign_beats: got %0d expected 256", n_beats); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ign_sequence: %0d wrong beats, first at %0d", bad, first_bad); end
        n_checks++; if (done_edge !== 512) begin n_fail++; $display("FAIL ign_done_time: got %0d expected 512", done_edge); end
        n_checks++; if (sat_at_done !== 9'd2) begin n_fail++; $display("FAIL ign_sat_count: got %0d expected 2", sat_at_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ign_done_start: busy got %0b expected 0", busy); end
`ifdef MEM_SCAN_CLEAR_EN
        n_checks++; if (wr_count !== 256) begin n_fail++; $display("FAIL ign_clear_writes: got %0d expected 256", wr_count); end
`endif
        // Back-to-back scan: start in the cycle right after DONE.
        for (int i = 0; i < DEPTH; i++) exp_data[i] = CLEAR ? 16'h0000 : exp_data[i];
        run_scan(0, -1, 1'b0);
        bad = count_bad();
        n_checks++; if (sat_first !== 9'd0) begin n_fail++; $display("FAIL b2b_sat_first: got %0d expected 0", sat_first); end
        n_checks++; if (n_beats !== 256) begin n_fail++; $display("FAIL b2b_beats: got %0d expected 256", n_beats); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_sequence: %0d wrong beats, first at %0d", bad, first_bad); end
        n_checks++; if (sat_at_done !== (CLEAR ? 9'd0 : 9'd2)) begin n_fail++; $display("FAIL b2b_sat_count: got %0d expected %0d", sat_at_done, CLEAR ? 0 : 2); end
    endtask

    task automatic test_reset_mid_scan();
        int cyc;
        int bad;
        load_preload();
`ifdef MEM_SCAN_CLEAR_EN
        wr_count = 0;
`endif
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc = 0;
        while (!(out_valid === 1'b1 && out_addr === 8'd37) && cyc < 1000) begin
            step();
            cyc++;
        end
        n_checks++; if (cyc >= 1000) begin n_fail++; $display("FAIL rst_reach_37: beat 37 not seen in %0d cycles", cyc); end
        out_ready = 1'b0;
        #1;
        rst = 1'b1;
        step();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %0b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        n_checks++; if (out_addr !== 8'h00) begin n_fail++; $display("FAIL rst_out_addr: got %0h expected 0", out_addr); end
        n_checks++; if (out_data !== 16'h0000) begin n_fail++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
        n_checks++; if (mem_addr !== 8'h00) begin n_fail++; $display("FAIL rst_mem_addr: got %0h expected 0", mem_addr); end
        n_checks++; if (sat_count !== 9'h000) begin n_fail++; $display("FAIL rst_sat_count: got %0h expected 0", sat_count); end
`ifdef MEM_SCAN_CLEAR_EN
        n_checks++; if (wr_count !== 37) begin n_fail++; $display("FAIL rst_partial_clear: got %0d writes expected 37", wr_count); end
`endif
        rst = 1'b0;
        step();
        // Beats 0..36 were accepted before the abort, so read-and-clear zeroed them.
        for (int i = 0; i < 37; i++) exp_data[i] = CLEAR ? 16'h0000 : exp_data[i];
        run_scan(0, -1, 1'b0);
        bad = count_bad();
        n_checks++; if (n_beats !== 256) begin n_fail++; $display("FAIL rescan_beats: got %0d expected 256", n_beats); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rescan_sequence: %0d wrong beats, first at %0d", bad, first_bad); end
        n_checks++; if (sat_at_done !== (CLEAR ? 9'd1 : 9'd2)) begin n_fail++; $display("FAIL rescan_sat_count: got %0d expected %0d", sat_at_done, CLEAR ? 1 : 2); end
    endtask

    task automatic test_all_ones();
        int bad;
        load_ones();
        run_scan(0, -1, 1'b0);
        bad = count_bad();
        n_checks++; if (n_beats !== 256) begin n_fail++; $display("FAIL ones_beats: got %0d expected 256", n_beats); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL ones_sequence: %0d wrong beats, first at %0d", bad, first_bad); end
        n_checks++; if (sat_at_done !== 9'h100) begin n_fail++; $display("FAIL ones_sat_count: got %0h expected 100", sat_at_done); end
    endtask

    initial begin
        test_reset();
        test_full_scan();
        test_backpressure();
        test_ignored_start();
        test_reset_mid_scan();
        test_all_ones();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
